req_priority_encoder: RTL and testbench
=======================================

Name: req_priority_encoder

Overview:
- Registered 4-to-2 priority encoder with request latching and a valid/ack handshake. This is the encoding counterpart of the 2-to-4 decoder.
- Collects multi-hot request lines into a pending register and presents the highest-priority index.
- Holds that index stable until the consumer acknowledges it, then clears that pending bit.
- Used to encode interrupt/exception request lines into an index for the MIPS control path.

Parameters:
- N_REQ, 4, number of request lines (power of 2, at least 2).
- IDX_W, 2, encoded index width; must equal log2(N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  request-capture enable; when 0, req is ignored.
- req  input  N_REQ  request lines, level-sampled each cycle.
- ack  input  1  consumer accepts the current index; meaningful only while valid=1.
- o  output  IDX_W  encoded index; stable while valid=1.
- valid  output  1  o holds a granted request.
- pending  output  N_REQ  current pending register, for debug/status.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, state=IDLE, o=0, valid=0.
  - Reset overrides all other activity, including mid-handshake; an outstanding grant is discarded.
- Priority: highest bit index wins (req[3] over req[2] over req[1] over req[0]). Encoding is binary: bit k maps to o=k.
- Pending update at every edge:
  - Start from pending | (en ? req : 0).
  - If state=HOLD and ack=1, clear bit idx.
  - Simultaneous set and clear of the same bit: set wins, so the bit stays pending and is re-granted later.
- State machine (2 states, outputs registered):
  - IDLE: valid=0, o holds its last value (0 after reset). If the registered pending is non-zero at the edge, go to HOLD and latch idx = encode(pending). Otherwise stay in IDLE.
  - HOLD: valid=1, o=idx. Newly arriving higher-priority requests do not pre-empt; o is frozen until ack. On ack=1, go to IDLE (default build). On ack=0, stay in HOLD.
- Latency:
  - req with en=1 in cycle c → pending bit visible in cycle c+1 → valid=1 in cycle c+2 (if IDLE).
  - Default build has a 1-cycle bubble (valid=0) between consecutive grants.
- ack while valid=0 is ignored and causes no state change.
- en=0 blocks new captures only. Already-pending bits and the handshake proceed normally.
- All pending bits clear and no req: remain IDLE, valid=0.
- req held high continuously with en=1: the bit re-sets after its ack and is granted again. This is intended level semantics.

Optional Feature:
- Macro: REQ_PRIO_FAST_REGRANT_EN.
- Defined: on ack in HOLD, let pending_after = pending with bit idx cleared, excluding same-cycle req.
  - If pending_after is non-zero: stay in HOLD, set idx = encode(pending_after), keep valid=1 (back-to-back grants, no bubble).
  - Otherwise go to IDLE.
- Undefined: ack always returns to IDLE, giving the 1-cycle bubble described above.

Decomposition:
- Shared package holds:
  - State encoding constants: ST_IDLE=1'b0, ST_HOLD=1'b1.
  - Default N_REQ/IDX_W constants.
- One natural sub-module: prio_encode_comb.
  - Purely combinational.
  - Input vector N_REQ, output index IDX_W plus an any-set flag.
  - Used for both the IDLE grant and the fast-regrant path.

Test Plan:
- Reset and idle: rst=1 for 2 cycles, then en=1, req=0 for 5 cycles → o=0, valid=0, pending=0 throughout.
- Single request: en=1, req=4'b0100 for 1 cycle → pending=4'b0100 next cycle; valid=1, o=2 two cycles after req; ack=1 one cycle → pending=0, valid=0 next cycle.
- Priority and no pre-emption: req=4'b0011 → o=1, valid=1. While held, pulse req=4'b1000 → o stays 1. After ack: default build shows valid=0 for 1 cycle, then o=3; then o=0 after the next ack.
- Enable gating: en=0, req=4'b1111 for 3 cycles → pending=0, valid=0. Then en=1 for 1 cycle → pending=4'b1111, o=3.
- Set-wins collision: in HOLD with o=2, apply ack=1 and req=4'b0100 in the same cycle → pending[2] stays 1; index 2 is granted again.
- Reset mid-handshake: valid=1, o=3, pending=4'b1010, assert rst → next cycle valid=0, o=0, pending=0. With REQ_PRIO_FAST_REGRANT_EN defined, also run pending=4'b1010 with an ack at o=3 → next cycle valid=1, o=1 with no bubble.

Source files
------------

// File: rtl/req_priority_encoder_pkg.sv
// Shared constants and state type for the request priority encoder.
package req_priority_encoder_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned IDX_W_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/req_priority_encoder_prio_encode_comb.sv
// Combinational priority encoder: highest set bit of vec wins, binary index out.
module prio_encode_comb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/req_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with request latching and valid/ack.
// Optional REQ_PRIO_FAST_REGRANT_EN: re-grant from remaining pending bits on ack.
module req_priority_encoder
  import req_priority_encoder_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [IDX_W-1:0] o,
  output logic             valid,
  output logic [N_REQ-1:0] pending
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N_REQ-1:0] pending_nxt;
  logic [N_REQ-1:0] set_bits, clr_bits;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_any;

  prio_encode_comb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_enc_pend (
    .vec (pending),
    .idx (pend_idx),
    .any (pend_any)
  );

`ifdef REQ_PRIO_FAST_REGRANT_EN
  logic [N_REQ-1:0] rest;
  logic [IDX_W-1:0] rest_idx;
  logic             rest_any;

  // Remaining work after this ack; same-cycle requests are deliberately excluded.
  assign rest = pending & ~clr_bits;

  prio_encode_comb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_enc_rest (
    .vec (rest),
    .idx (rest_idx),
    .any (rest_any)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    set_bits    = en ? req : '0;
    clr_bits    = (state == ST_HOLD && ack) ? (ONE << idx) : '0;
    // Set is applied after clear so a re-asserted request survives its own ack.
    pending_nxt = (pending & ~clr_bits) | set_bits;
    state_nxt   = state;
    idx_nxt     = idx;
    case (state)
      ST_IDLE: begin
        if (pend_any) begin
          state_nxt = ST_HOLD;
          idx_nxt   = pend_idx;
        end
      end
      ST_HOLD: begin
        if (ack) begin
`ifdef REQ_PRIO_FAST_REGRANT_EN
          if (rest_any) idx_nxt = rest_idx;
          else          state_nxt = ST_IDLE;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o     = idx;
  assign valid = (state == ST_HOLD);

endmodule

// File: tb/tb_req_priority_encoder.sv
// Randomized + directed self-checking bench for req_priority_encoder.
module tb_req_priority_encoder;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [3:0] req;
  logic [1:0] o;
  logic       valid;
  logic [3:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a set of waiting request numbers and the current grant.
  bit m_pend [4];
  bit m_valid;
  int m_o;

  req_priority_encoder #(.N_REQ(4), .IDX_W(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .ack     (ack),
    .o       (o),
    .valid   (valid),
    .pending (pending)
  );

  always #5 clk = ~clk;

  function automatic int highest(input bit v [4]);
    for (int k = 3; k >= 0; k--) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [3:0] m_pend_vec();
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = m_pend[k];
    return r;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [3:0] rq, input logic a);
    bit nxt [4];
    bit rest [4];
    bool_done: begin end
    if (r) begin
      for (int k = 0; k < 4; k++) m_pend[k] = 0;
      m_valid = 0;
      m_o     = 0;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      rest[k] = m_pend[k] && !(m_valid && a && k == m_o);
      nxt[k]  = rest[k] || (e && rq[k]);
    end
    if (!m_valid) begin
      if (highest(m_pend) >= 0) begin
        m_valid = 1;
        m_o     = highest(m_pend);
      end
    end else if (a) begin
`ifdef REQ_PRIO_FAST_REGRANT_EN
      if (highest(rest) >= 0) m_o = highest(rest);
      else m_valid = 0;
`else
      m_valid = 0;
`endif
    end
    m_pend = nxt;
  endtask

  task automatic tick(input logic r, input logic e, input logic [3:0] rq, input logic a);
    rst = r; en = e; req = rq; ack = a;
    @(posedge clk);
    model_step(r, e, rq, a);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 2) tick(1'b1, 1'b0, 4'b0000, 1'b0);
      else       tick(1'b0, 1'b1, 4'b0000, 1'b0);
      n_cmp++;
      if ({o, valid, pending} !== 7'd0 || m_pend_vec() !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d: o=%0d valid=%0b pending=%b, want all zero", c, o, valid, pending);
      end
    end
  endtask

  task automatic test_single();
    tick(1'b0, 1'b1, 4'b0100, 1'b0);
    n_cmp++;
    if (pending !== 4'b0100 || valid !== 1'b0) begin
      n_bad++; $display("FAIL single_capture: pending=%b valid=%0b want 0100/0", pending, valid);
    end
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd2) begin
      n_bad++; $display("FAIL single_grant: valid=%0b o=%0d want 1/2", valid, o);
    end
    tick(1'b0, 1'b1, 4'b0000, 1'b1);
    n_cmp++;
    if (valid !== 1'b0 || pending !== 4'b0000) begin
      n_bad++; $display("FAIL single_ack: valid=%0b pending=%b want 0/0000", valid, pending);
    end
  endtask

  task automatic drain(input string name);
    int budget = 20;
    while ((m_valid || highest(m_pend) >= 0) && budget > 0) begin
      tick(1'b0, 1'b1, 4'b0000, m_valid);
      budget--;
      n_cmp++;
      if (o !== 2'(m_o) || valid !== m_valid || pending !== m_pend_vec()) begin
        n_bad++;
        $display("FAIL %s_drain: o=%0d valid=%0b pending=%b want %0d/%0b/%b", name, o, valid, pending, m_o, m_valid, m_pend_vec());
      end
    end
    if (budget == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain_timeout: still busy, want idle", name);
    end
  endtask

  task automatic test_priority();
    tick(1'b0, 1'b1, 4'b0011, 1'b0);
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd1) begin
      n_bad++; $display("FAIL prio_first: valid=%0b o=%0d want 1/1", valid, o);
    end
    tick(1'b0, 1'b1, 4'b1000, 1'b0);
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd1 || pending !== 4'b1011) begin
      n_bad++; $display("FAIL prio_no_preempt: valid=%0b o=%0d pending=%b want 1/1/1011", valid, o, pending);
    end
    tick(1'b0, 1'b1, 4'b0000, 1'b1);
`ifdef REQ_PRIO_FAST_REGRANT_EN
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd3) begin
      n_bad++; $display("FAIL prio_regrant: valid=%0b o=%0d want 1/3", valid, o);
    end
`else
    n_cmp++;
    if (valid !== 1'b0 || pending !== 4'b1001) begin
      n_bad++; $display("FAIL prio_bubble: valid=%0b pending=%b want 0/1001", valid, pending);
    end
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd3) begin
      n_bad++; $display("FAIL prio_second: valid=%0b o=%0d want 1/3", valid, o);
    end
`endif
    drain("prio");
    n_cmp++;
    if (o !== 2'd0 || valid !== 1'b0) begin
      n_bad++; $display("FAIL prio_last: o=%0d valid=%0b want 0/0", o, valid);
    end
  endtask

  task automatic test_enable();
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0, 4'b1111, c == 1);
      n_cmp++;
      if (pending !== 4'b0000 || valid !== 1'b0) begin
        n_bad++; $display("FAIL enable_gate c=%0d: pending=%b valid=%0b want 0000/0", c, pending, valid);
      end
    end
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    n_cmp++;
    if (pending !== 4'b1111) begin
      n_bad++; $display("FAIL enable_capture: pending=%b want 1111", pending);
    end
    tick(1'b0, 1'b0, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd3) begin
      n_bad++; $display("FAIL enable_grant: valid=%0b o=%0d want 1/3", valid, o);
    end
    drain("enable");
  endtask

  task automatic test_collision();
    tick(1'b0, 1'b1, 4'b0100, 1'b0);
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    tick(1'b0, 1'b1, 4'b0100, 1'b1);
    n_cmp++;
    if (pending !== 4'b0100 || valid !== 1'b0) begin
      n_bad++; $display("FAIL collision_setwins: pending=%b valid=%0b want 0100/0", pending, valid);
    end
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd2) begin
      n_bad++; $display("FAIL collision_regrant: valid=%0b o=%0d want 1/2", valid, o);
    end
    drain("collision");
  endtask

  task automatic test_reset_mid();
    tick(1'b0, 1'b1, 4'b1010, 1'b0);
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd3 || pending !== 4'b1010) begin
      n_bad++; $display("FAIL midreset_setup: valid=%0b o=%0d pending=%b want 1/3/1010", valid, o, pending);
    end
    tick(1'b1, 1'b1, 4'b0000, 1'b1);
    n_cmp++;
    if (valid !== 1'b0 || o !== 2'd0 || pending !== 4'b0000) begin
      n_bad++; $display("FAIL midreset: valid=%0b o=%0d pending=%b want 0/0/0000", valid, o, pending);
    end
    tick(1'b0, 1'b1, 4'b1010, 1'b0);
    tick(1'b0, 1'b1, 4'b0000, 1'b0);
    tick(1'b0, 1'b1, 4'b0000, 1'b1);
`ifdef REQ_PRIO_FAST_REGRANT_EN
    n_cmp++;
    if (valid !== 1'b1 || o !== 2'd1 || pending !== 4'b0010) begin
      n_bad++; $display("FAIL fast_no_bubble: valid=%0b o=%0d pending=%b want 1/1/0010", valid, o, pending);
    end
`else
    n_cmp++;
    if (valid !== 1'b0 || pending !== 4'b0010) begin
      n_bad++; $display("FAIL ack_bubble: valid=%0b pending=%b want 0/0010", valid, pending);
    end
`endif
    drain("midreset");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
      n_cmp++;
      if (o !== 2'(m_o) || valid !== m_valid || pending !== m_pend_vec()) begin
        n_bad++;
        $display("FAIL random c=%0d: o=%0d valid=%0b pending=%b want %0d/%0b/%b", c, o, valid, pending, m_o, m_valid, m_pend_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 4'b0000; ack = 1'b0;
    m_valid = 0; m_o = 0;
    for (int k = 0; k < 4; k++) m_pend[k] = 0;
    test_reset();
    test_single();
    test_priority();
    test_enable();
    test_collision();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
